// File: rtl/axil_ram_scoreboard.sv
// axil_ram_scoreboard: passive checker for an AXI4-Lite RAM slave, shadowing a window of words.
// Latency: a write commits one cycle after both AW and W heads are present; flags/counters update one cycle after the R/B handshake.
// Backpressure: none exerted (pure tap); a push into a full tracking FIFO is dropped and raises proto.

module axil_ram_scoreboard_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (PW+1)'(DEPTH));
  assign head_dat = mem[rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module axil_ram_scoreboard #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    STRB_WIDTH    = DATA_WIDTH/8,
  parameter int                    TRACK_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] TRACK_BASE    = '0,
  parameter int                    INIT_ZERO     = 1,
  parameter int                    WR_FIFO_DEPTH = 4,
  parameter int                    RD_FIFO_DEPTH = 4,
  parameter int                    CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  input  logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  input  logic                  s_axil_wready,
  input  logic [1:0]            s_axil_bresp,
  input  logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  input  logic                  s_axil_arready,
  input  logic [DATA_WIDTH-1:0] s_axil_rdata,
  input  logic [1:0]            s_axil_rresp,
  input  logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [2:0]            err_flags,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  check_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] err_exp,
  output logic [DATA_WIDTH-1:0] err_act
);
  localparam int                  WORDS      = 2**TRACK_WIDTH;
  localparam int                  BSHIFT     = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH:0] WIN_BYTES  = (ADDR_WIDTH+1)'(WORDS*STRB_WIDTH);
  localparam bit                  ZERO_KNOWN = (INIT_ZERO != 0);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } wbeat_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  chk;
    logic [DATA_WIDTH-1:0] exp;
  } rd_exp_t;

  // Shadow of the tracked window; deliberately survives reset like the RAM it mirrors.
  logic [DATA_WIDTH-1:0] shadow [WORDS];
  logic [WORDS-1:0]      known;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid  && s_axil_wready;
  assign b_hs  = s_axil_bvalid  && s_axil_bready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;
  assign r_hs  = s_axil_rvalid  && s_axil_rready;

  logic [ADDR_WIDTH-1:0] aw_head;
  wbeat_t                w_push, w_head;
  rd_exp_t               ar_push, ar_head;
  logic aw_empty, aw_full, w_empty, w_full, ar_empty, ar_full;
  logic commit;

  assign commit = !aw_empty && !w_empty;
  assign w_push = '{data: s_axil_wdata, strb: s_axil_wstrb};

  axil_ram_scoreboard_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(WR_FIFO_DEPTH)) u_aw_fifo (
    .clk(clk), .rst(rst), .push(aw_hs), .push_dat(s_axil_awaddr), .pop(commit),
    .head_dat(aw_head), .empty(aw_empty), .full(aw_full)
  );

  axil_ram_scoreboard_fifo #(.WIDTH($bits(wbeat_t)), .DEPTH(WR_FIFO_DEPTH)) u_w_fifo (
    .clk(clk), .rst(rst), .push(w_hs), .push_dat(w_push), .pop(commit),
    .head_dat(w_head), .empty(w_empty), .full(w_full)
  );

  axil_ram_scoreboard_fifo #(.WIDTH($bits(rd_exp_t)), .DEPTH(RD_FIFO_DEPTH)) u_ar_fifo (
    .clk(clk), .rst(rst), .push(ar_hs), .push_dat(ar_push), .pop(r_hs),
    .head_dat(ar_head), .empty(ar_empty), .full(ar_full)
  );

  // Window decode for the committing write and the incoming read.
  logic [ADDR_WIDTH-1:0]  cm_off, ar_off;
  logic                   cm_hit, ar_hit;
  logic [TRACK_WIDTH-1:0] cm_idx, ar_idx;
  assign cm_off = aw_head - TRACK_BASE;
  assign ar_off = s_axil_araddr - TRACK_BASE;
  assign cm_hit = (aw_head >= TRACK_BASE) && ({1'b0, cm_off} < WIN_BYTES);
  assign ar_hit = (s_axil_araddr >= TRACK_BASE) && ({1'b0, ar_off} < WIN_BYTES);
  assign cm_idx = cm_off[BSHIFT +: TRACK_WIDTH];
  assign ar_idx = ar_off[BSHIFT +: TRACK_WIDTH];

  logic [7:0] b_pend;
  logic       wr_busy;
  assign wr_busy = !aw_empty || !w_empty || (b_pend != '0) || aw_hs || w_hs;

  // Merge strobed bytes of the committing beat over the current (or implicit zero) word.
  logic [DATA_WIDTH-1:0] cm_word;
  always_comb begin
    cm_word = known[cm_idx] ? shadow[cm_idx] : '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (w_head.strb[i]) cm_word[8*i +: 8] = w_head.data[8*i +: 8];
    end
  end

  // Capture the expectation at AR time using the pre-commit shadow.
  always_comb begin
    ar_push      = '0;
    ar_push.addr = s_axil_araddr;
    ar_push.chk  = ar_hit && (known[ar_idx] || ZERO_KNOWN) && !wr_busy;
    ar_push.exp  = known[ar_idx] ? shadow[ar_idx] : '0;
  end

  // Shadow update on commit; no reset by design.
  always_ff @(posedge clk) begin
    if (commit && cm_hit) begin
      shadow[cm_idx] <= cm_word;
      known[cm_idx]  <= 1'b1;
    end
  end

  // Error event decode, one bit per channel group.
  logic aw_ovf, w_ovf, ar_ovf, b_proto, r_proto, b_resp_err, r_resp_err, r_chk, data_mis;
  logic wr_evt, rd_evt;
  assign aw_ovf     = aw_hs && aw_full && !commit;
  assign w_ovf      = w_hs  && w_full  && !commit;
  assign ar_ovf     = ar_hs && ar_full && !r_hs;
  assign b_proto    = b_hs && (b_pend == '0) && !commit;
  assign r_proto    = r_hs && ar_empty;
  assign b_resp_err = b_hs && (s_axil_bresp != 2'b00);
  assign r_resp_err = r_hs && (s_axil_rresp != 2'b00);
  assign r_chk      = r_hs && !ar_empty && ar_head.chk;
  assign data_mis   = r_chk && (s_axil_rdata != ar_head.exp);
  assign wr_evt     = aw_ovf || w_ovf || b_proto || b_resp_err;
  assign rd_evt     = ar_ovf || r_proto || r_resp_err || data_mis;

  logic [CNT_WIDTH:0] ec_sum;
  assign ec_sum = {1'b0, err_count} + (CNT_WIDTH+1)'({1'b0, wr_evt} + {1'b0, rd_evt});

  // Outstanding-B tracking: commit adds one, accepted B removes one.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_pend <= '0;
    end else begin
      case ({commit, b_hs && !b_proto})
        2'b10:   b_pend <= b_pend + 1'b1;
        2'b01:   b_pend <= b_pend - 1'b1;
        default: b_pend <= b_pend;
      endcase
    end
  end

  // Sticky flags, saturating counters and first-mismatch capture.
  logic captured;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags   <= '0;
      err_count   <= '0;
      check_count <= '0;
      err_addr    <= '0;
      err_exp     <= '0;
      err_act     <= '0;
      captured    <= 1'b0;
    end else begin
      err_flags[2] <= err_flags[2] | aw_ovf | w_ovf | ar_ovf | b_proto | r_proto;
      err_flags[1] <= err_flags[1] | b_resp_err | r_resp_err;
      err_flags[0] <= err_flags[0] | data_mis;
      err_count    <= ec_sum[CNT_WIDTH] ? '1 : ec_sum[CNT_WIDTH-1:0];
      if (r_chk && (check_count != '1)) check_count <= check_count + 1'b1;
      if (data_mis && !captured) begin
        captured <= 1'b1;
        err_addr <= ar_head.addr;
        err_exp  <= ar_head.exp;
        err_act  <= s_axil_rdata;
      end
    end
  end
endmodule

// File: tb/tb_axil_ram_scoreboard.sv
// Bench for axil_ram_scoreboard: drives both sides of the tapped AXI4-Lite link.
// Expected outputs come from a word-array RAM model and a queue of outstanding reads.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_axil_ram_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [2:0]  err_flags;
  logic [15:0] err_count, check_count, err_addr;
  logic [31:0] err_exp, err_act;

  always #5 clk = ~clk;

  axil_ram_scoreboard dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .err_flags(err_flags), .err_count(err_count), .check_count(check_count),
    .err_addr(err_addr), .err_exp(err_exp), .err_act(err_act)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: RAM contents as seen by a correct slave, plus expected scoreboard outputs.
  typedef struct {
    logic [15:0] addr;
    bit          chk;
    logic [31:0] exp;
  } rq_t;

  logic [31:0] mem [16];
  rq_t         rq [$];
  int          wr_open = 0;
  bit          allow_stall = 1'b1;
  logic [2:0]  m_flags = '0;
  int          m_ec = 0;
  int          m_cc = 0;
  bit          m_cap = 1'b0;
  logic [15:0] m_eaddr = '0;
  logic [31:0] m_eexp = '0;
  logic [31:0] m_eact = '0;

  function automatic bit in_win(input logic [15:0] a);
    return int'(a) < 64;
  endfunction

  function automatic void model_commit(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (!in_win(a)) return;
    idx = int'(a) / 4;
    for (int b = 0; b < 4; b++) if (s[b]) mem[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".flags"}, 64'(err_flags), 64'(m_flags));
    check_val({tag, ".err_count"}, 64'(err_count), 64'(m_ec));
    check_val({tag, ".check_count"}, 64'(check_count), 64'(m_cc));
    check_val({tag, ".err_addr"}, 64'(err_addr), 64'(m_eaddr));
    check_val({tag, ".err_exp"}, 64'(err_exp), 64'(m_eexp));
    check_val({tag, ".err_act"}, 64'(err_act), 64'(m_eact));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_aw(input logic [15:0] a);
    awaddr = a;
    if (allow_stall && $urandom_range(0, 3) == 0) begin awvalid = 1; awready = 0; @(negedge clk); end
    awvalid = 1; awready = 1; @(negedge clk);
    awvalid = 0; awready = 0;
  endtask

  task automatic pulse_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s;
    if (allow_stall && $urandom_range(0, 3) == 0) begin wvalid = 1; wready = 0; @(negedge clk); end
    wvalid = 1; wready = 1; @(negedge clk);
    wvalid = 0; wready = 0;
  endtask

  task automatic pulse_b(input logic [1:0] r);
    bresp = r;
    if (allow_stall && $urandom_range(0, 3) == 0) begin bvalid = 1; bready = 0; @(negedge clk); end
    bvalid = 1; bready = 1; @(negedge clk);
    bvalid = 0; bready = 0; bresp = 0;
  endtask

  task automatic pulse_ar(input logic [15:0] a);
    araddr = a;
    if (allow_stall && $urandom_range(0, 3) == 0) begin arvalid = 1; arready = 0; @(negedge clk); end
    arvalid = 1; arready = 1; @(negedge clk);
    arvalid = 0; arready = 0;
  endtask

  task automatic pulse_r(input logic [31:0] d);
    rdata = d; rresp = 0;
    if (allow_stall && $urandom_range(0, 3) == 0) begin rvalid = 1; rready = 0; @(negedge clk); end
    rvalid = 1; rready = 1; @(negedge clk);
    rvalid = 0; rready = 0;
  endtask

  // Full write transaction; the B response is only returned once the write has settled.
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    input bit aw_first, input logic [1:0] resp);
    wr_open++;
    if (aw_first) begin pulse_aw(a); idle($urandom_range(0, 2)); pulse_w(d, s); end
    else          begin pulse_w(d, s); idle($urandom_range(0, 2)); pulse_aw(a); end
    idle(1 + $urandom_range(0, 1));
    model_commit(a, d, s);
    pulse_b(resp);
    if (resp != 0) begin m_flags[1] = 1'b1; m_ec++; end
    wr_open--;
  endtask

  // Read address phase: a checked read needs a tracked word and no write activity.
  task automatic issue_ar(input logic [15:0] a);
    rq_t e;
    pulse_ar(a);
    if (rq.size() >= 4) begin
      m_flags[2] = 1'b1; m_ec++;
    end else begin
      e.addr = a;
      e.chk  = in_win(a) && (wr_open == 0);
      e.exp  = in_win(a) ? mem[int'(a) / 4] : 32'h0;
      rq.push_back(e);
    end
  endtask

  // Read data phase: a correct slave returns current RAM contents unless data is forced.
  task automatic complete_r(input bit use_given, input logic [31:0] given);
    rq_t e;
    logic [31:0] d;
    if (rq.size() == 0) begin
      pulse_r(use_given ? given : $urandom);
      m_flags[2] = 1'b1; m_ec++;
      return;
    end
    e = rq.pop_front();
    d = use_given ? given : (in_win(e.addr) ? mem[int'(e.addr) / 4] : $urandom);
    pulse_r(d);
    if (e.chk) begin
      m_cc++;
      if (d !== e.exp) begin
        m_flags[0] = 1'b1; m_ec++;
        if (!m_cap) begin m_cap = 1'b1; m_eaddr = e.addr; m_eexp = e.exp; m_eact = d; end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    m_flags = '0; m_ec = 0; m_cc = 0; m_cap = 1'b0;
    m_eaddr = '0; m_eexp = '0; m_eact = '0;
    rq.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    awaddr = 0; awvalid = 0; awready = 0; wdata = 0; wstrb = 0; wvalid = 0; wready = 0;
    bresp = 0; bvalid = 0; bready = 0; araddr = 0; arvalid = 0; arready = 0;
    rdata = 0; rresp = 0; rvalid = 0; rready = 0; rst = 1;
    idle(3);
    do_reset();
    idle(1);
    check_all("reset");

    // Full-word write then checked read.
    wr(16'h4, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00);
    issue_ar(16'h4); complete_r(1'b0, 0);
    check_all("wr_rd");
    check_val("wr_rd.count_is_1", 64'(check_count), 64'd1);

    // W before AW, low two bytes only.
    wr(16'h4, 32'h00001234, 4'h3, 1'b0, 2'b00);
    issue_ar(16'h4); complete_r(1'b1, 32'hDEAD1234);
    check_all("w_first_merge");

    // Read while a write is still open: no compare even with wrong data.
    wr_open++;
    pulse_aw(16'h8); pulse_w(32'hA5A5A5A5, 4'hF);
    issue_ar(16'h8);
    idle(1); model_commit(16'h8, 32'hA5A5A5A5, 4'hF);
    pulse_b(0); wr_open--;
    complete_r(1'b1, 32'h0BAD0BAD);
    check_all("ar_while_busy");

    // Four back-to-back reads with rready low, then drained in order.
    wr(16'h0, $urandom, 4'hF, 1'b1, 2'b00);
    wr(16'hC, $urandom, 4'hF, 1'b0, 2'b00);
    allow_stall = 1'b0;
    issue_ar(16'h0); issue_ar(16'h4); issue_ar(16'h8); issue_ar(16'hC);
    idle(2);
    for (int i = 0; i < 4; i++) complete_r(1'b0, 0);
    allow_stall = 1'b1;
    check_all("ar_x4");

    // First data mismatch captured.
    wr(16'h4, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00);
    issue_ar(16'h4); complete_r(1'b1, 32'h0);
    check_all("mismatch");
    check_val("mismatch.flags_exact", 64'(err_flags), 64'h1);

    // R with nothing outstanding.
    complete_r(1'b0, 0);
    check_all("r_empty");

    // AW FIFO: pop+push when full is legal, a further push overflows.
    allow_stall = 1'b0;
    for (int i = 0; i < 4; i++) pulse_aw(16'h200);
    pulse_w(32'h1, 4'hF);
    pulse_aw(16'h200);
    check_all("aw_full_pushpop");
    pulse_aw(16'h200);
    m_flags[2] = 1'b1; m_ec++;
    check_all("aw_overflow");
    for (int i = 0; i < 4; i++) pulse_w(32'h2, 4'hF);
    idle(1);
    for (int i = 0; i < 5; i++) pulse_b(0);
    check_all("aw_drain");
    pulse_b(0);
    m_flags[2] = 1'b1; m_ec++;
    check_all("b_no_pending");

    // W FIFO overflow.
    for (int i = 0; i < 5; i++) pulse_w(32'h3, 4'hF);
    m_flags[2] = 1'b1; m_ec++;
    check_all("w_overflow");
    for (int i = 0; i < 4; i++) pulse_aw(16'h300);
    idle(1);
    for (int i = 0; i < 4; i++) pulse_b(0);
    check_all("w_drain");
    allow_stall = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) wr(16'(4 * i), $urandom, 4'hF, 1'($urandom_range(0, 1)), 2'b00);
    check_all("sweep");
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = ($urandom_range(0, 4) != 0) ? 16'(4 * $urandom_range(0, 15)) : 16'(16'h400 + 4 * $urandom_range(0, 63));
          wr(a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 2'b00);
        end
        2: begin
          a = ($urandom_range(0, 4) != 0) ? 16'(4 * $urandom_range(0, 15)) : 16'(16'h100 + 4 * $urandom_range(0, 63));
          issue_ar(a); idle($urandom_range(0, 2)); complete_r(1'b0, 0);
        end
        default: begin
          a = 16'(4 * $urandom_range(0, 15));
          d = $urandom;
          wr_open++;
          pulse_aw(a); pulse_w(d, 4'hF);
          issue_ar(16'(4 * $urandom_range(0, 15)));
          idle(1); model_commit(a, d, 4'hF);
          pulse_b(0); wr_open--;
          complete_r(1'b1, $urandom);
        end
      endcase
      check_all("rand");
    end

    // Shadow survives reset; bresp error sets resp flag.
    wr(16'h8, 32'h00000055, 4'hF, 1'b1, 2'b00);
    idle(1);
    do_reset();
    check_all("post_reset");
    issue_ar(16'h8); complete_r(1'b1, 32'h00000055);
    check_all("shadow_kept");
    wr(16'hC, $urandom, 4'hF, 1'b1, 2'b10);
    check_all("bresp_err");
    check_val("bresp_err.flags_exact", 64'(err_flags), 64'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
